alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, as listed below.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
REQ-002 The block SHALL provide one request port and one response port per requester x in {0,1}:
- reqx_valid  input  1  requester x presents an operation.
- reqx_ready  output  1  arbiter accepts requester x's operation this cycle.
- reqx_src1  input  32  operand 1.
- reqx_src2  input  32  operand 2.
- reqx_ctrl  input  4  ALU control code.
- reqx_comp  input  3  compare sub-code; used only when reqx_ctrl is COMP.
- rspx_valid  output  1  result for requester x is available.
- rspx_ready  input  1  requester x takes the result.
- rspx_result  output  32  ALU result.
- rspx_zero, rspx_cout, rspx_ovf  output  1 each  ALU flags.
REQ-003 The block SHALL also provide these status outputs:
- grant_o  output  2  one-hot owner of the operation in flight; 0 when idle.
- busy_o  output  1  high in EXEC and RESP.

Function
REQ-004 The block SHALL instantiate one ALU and share it between the two requesters, with at most one operation in flight.
REQ-005 The FSM SHALL have the states IDLE, EXEC and RESP.
- IDLE -> EXEC on any accepted request.
- EXEC -> RESP unconditionally.
- RESP -> IDLE when the owner's rsp_ready is high.
REQ-006 In IDLE, reqx_ready SHALL be driven combinationally high only for the arbitration winner.
- Winner is the single valid requester, or the priority-pointer requester when both are valid.
- All reqx_ready SHALL be low in EXEC and RESP.
REQ-007 On acceptance (valid & ready), the block SHALL register src1, src2, ctrl, comp and the owner ID.
REQ-008 In EXEC, the ALU SHALL be driven from the registered operands, and its result and flags SHALL be registered at the end of the cycle.
REQ-009 Latency: a request accepted in cycle N SHALL assert rspx_valid in cycle N+2; minimum spacing between accepts is 3 cycles.
REQ-010 rspx_valid SHALL be asserted only for the owner, and result and flags SHALL stay stable until the rsp_ready handshake.
REQ-011 The priority pointer SHALL update when a response completes: it points to the requester that was not just served.
REQ-012 ctrl and comp codes SHALL pass to the ALU unchanged, with no checking of legal codes.

Reset
REQ-013 While rst_n is low at a clock edge, the block SHALL clear the following state:
- FSM goes to IDLE and the pointer to requester 0.
- All rspx_valid, reqx_ready, grant_o and busy_o go to 0.
- Result, flag and operand registers go to 0.
REQ-014 A reset during EXEC or RESP SHALL discard the in-flight operation, with no response issued afterwards.
REQ-015 The ALU's rst_n input SHALL be tied to rst_n.

Configuration
REQ-016 The block SHALL implement the macro ALU_ARB_FLAGS_EN as follows:
- Defined: rspx_zero, rspx_cout and rspx_ovf carry the registered ALU flags.
- Undefined: these outputs are tied to 0 and no flag registers are built.
- rspx_result behaviour is identical in both cases.

Structure
REQ-017 The shared package alu_arb_pkg SHALL hold the following:
- The FSM state typedef.
- ALU control constants: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, NAND 1101, COMP 0111.
- COMP sub-codes: SLT 000, SGT 001, SLE 010, SLTU 101.
REQ-018 The block SHALL contain exactly one sub-module: the existing alu, instantiated once.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- req0 ADD 5+7 accepted in cycle N -> rsp0_valid in N+2, result 12, zero 0.
- After reset, req0 and req1 valid in the same cycle -> req0 served first, then req1; continuous requests alternate 0,1,0,1.
- rsp0_ready held low 3 cycles -> rsp0 result stable, req1_ready stays 0, req1 accepted in the cycle after the rsp0 handshake.
- With ALU_ARB_FLAGS_EN, SUB 0x80000000-1 -> result 0x7FFFFFFF, ovf 1; SUB 3-3 -> result 0, zero 1.
- COMP/SLT with src1 0xFFFFFFFF (-1), src2 1 -> result 1; SLTU with the same operands -> result 0.
- rst_n low during EXEC -> no rspx_valid afterwards, grant_o 0, next request served normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared FSM state, ALU control and compare codes for alu_arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [3:0] ALU_COMP = 4'b0111;

  localparam logic [2:0] CMP_SLT  = 3'b000;
  localparam logic [2:0] CMP_SGT  = 3'b001;
  localparam logic [2:0] CMP_SLE  = 3'b010;
  localparam logic [2:0] CMP_SLTU = 3'b101;

  typedef struct packed {
    logic zero;
    logic cout;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU shared by the arbiter
module alu
  import alu_arb_pkg::*;
(
  input  logic        rst_n,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ctrl,
  input  logic [2:0]  comp,
  output logic [31:0] result,
  output alu_flags_t  flags
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] res;
  logic        cout;
  logic        ovf;

  // Subtraction is a + ~b + 1, so cout means "no borrow".
  assign sum  = {1'b0, src1} + {1'b0, src2};
  assign diff = {1'b0, src1} + {1'b0, ~src2} + 33'd1;

  always_comb begin
    res  = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (ctrl)
      ALU_AND:  res = src1 & src2;
      ALU_OR:   res = src1 | src2;
      ALU_NOR:  res = ~(src1 | src2);
      ALU_NAND: res = ~(src1 & src2);
      ALU_ADD: begin
        res  = sum[31:0];
        cout = sum[32];
        ovf  = (src1[31] == src2[31]) && (sum[31] != src1[31]);
      end
      ALU_SUB: begin
        res  = diff[31:0];
        cout = diff[32];
        ovf  = (src1[31] != src2[31]) && (diff[31] != src1[31]);
      end
      ALU_COMP: begin
        case (comp)
          CMP_SLT:  res = {31'd0, $signed(src1) <  $signed(src2)};
          CMP_SGT:  res = {31'd0, $signed(src1) >  $signed(src2)};
          CMP_SLE:  res = {31'd0, $signed(src1) <= $signed(src2)};
          CMP_SLTU: res = {31'd0, src1 < src2};
          default:  res = '0;
        endcase
      end
      default: res = '0;
    endcase
    // Outputs are held quiet while in reset.
    if (!rst_n) begin
      res  = '0;
      cout = 1'b0;
      ovf  = 1'b0;
    end
  end

  assign result     = res;
  assign flags.zero = rst_n && (res == 32'd0);
  assign flags.cout = cout;
  assign flags.ovf  = ovf;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter around one shared ALU; ALU_ARB_FLAGS_EN enables flag outputs
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [3:0]  req0_ctrl,
  input  logic [2:0]  req0_comp,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_cout,
  output logic        rsp0_ovf,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [3:0]  req1_ctrl,
  input  logic [2:0]  req1_comp,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_cout,
  output logic        rsp1_ovf,

  output logic [1:0]  grant_o,
  output logic        busy_o
);

  state_t      state;
  logic        ptr;
  logic        owner;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [3:0]  ctrl_q;
  logic [2:0]  comp_q;
  logic [31:0] result_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [1:0]  grant_q;
  logic        busy_q;

  logic        winner;
  logic        accept;
  logic        owner_rsp_ready;
  logic [31:0] alu_result;
  alu_flags_t  alu_flags;

  // Pointer only breaks ties; a lone requester always wins.
  assign winner          = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign accept          = rst_n && (state == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready      = accept && !winner;
  assign req1_ready      = accept && winner;
  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  alu u_alu (
    .rst_n  (rst_n),
    .src1   (src1_q),
    .src2   (src2_q),
    .ctrl   (ctrl_q),
    .comp   (comp_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      ctrl_q       <= '0;
      comp_q       <= '0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            src1_q  <= winner ? req1_src1 : req0_src1;
            src2_q  <= winner ? req1_src2 : req0_src2;
            ctrl_q  <= winner ? req1_ctrl : req0_ctrl;
            comp_q  <= winner ? req1_comp : req0_comp;
            owner   <= winner;
            grant_q <= winner ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q     <= alu_result;
          rsp0_valid_q <= !owner;
          rsp1_valid_q <= owner;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            ptr          <= !owner;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  alu_flags_t flags_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (state == S_EXEC) begin
      flags_q <= alu_flags;
    end
  end

  assign rsp0_zero = flags_q.zero;
  assign rsp0_cout = flags_q.cout;
  assign rsp0_ovf  = flags_q.ovf;
  assign rsp1_zero = flags_q.zero;
  assign rsp1_cout = flags_q.cout;
  assign rsp1_ovf  = flags_q.ovf;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;

  assign rsp0_zero = 1'b0;
  assign rsp0_cout = 1'b0;
  assign rsp0_ovf  = 1'b0;
  assign rsp1_zero = 1'b0;
  assign rsp1_cout = 1'b0;
  assign rsp1_ovf  = 1'b0;
`endif

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with directed vectors
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [31:0] req0_src1, req0_src2, rsp0_result;
  logic [3:0]  req0_ctrl;
  logic [2:0]  req0_comp;
  logic        rsp0_zero, rsp0_cout, rsp0_ovf;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req1_src1, req1_src2, rsp1_result;
  logic [3:0]  req1_ctrl;
  logic [2:0]  req1_comp;
  logic        rsp1_zero, rsp1_cout, rsp1_ovf;
  logic [1:0]  grant_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  alu_arbiter dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_ctrl(req0_ctrl), .req0_comp(req0_comp),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_cout(rsp0_cout), .rsp0_ovf(rsp0_ovf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_ctrl(req1_ctrl), .req1_comp(req1_comp),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_cout(rsp1_cout), .rsp1_ovf(rsp1_ovf),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic [2:0]  comp;
    logic [31:0] res;
    logic        z, c, v;
  } op_t;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        z, c, v;
    int          acc;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   order[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cyc1 = -1;
  int   hs_cyc0 = -1;
  logic        seen[2];
  logic [31:0] hold_res[2];

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                             input logic [2:0] comp, input logic [31:0] res,
                             input logic z, input logic c, input logic v);
    op_t o;
    o.src1 = a; o.src2 = b; o.ctrl = ctrl; o.comp = comp;
    o.res = res; o.z = z; o.c = c; o.v = v;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int p, input op_t o);
    exp_t e;
    e.port = p;
    e.res  = o.res;
`ifdef ALU_ARB_FLAGS_EN
    e.z = o.z; e.c = o.c; e.v = o.v;
`else
    e.z = 1'b0; e.c = 1'b0; e.v = 1'b0;
`endif
    e.acc = cyc;
    sb.push_back(e);
    order.push_back(p);
    if (p == 1) acc_cyc1 = cyc;
  endtask

  // Driver: presents the head of each per-port queue, records accepts.
  initial begin
    logic a0, a1;
    req0_valid = 0; req0_src1 = '0; req0_src2 = '0; req0_ctrl = '0; req0_comp = '0;
    req1_valid = 0; req1_src1 = '0; req1_src2 = '0; req1_ctrl = '0; req1_comp = '0;
    forever begin
      @(negedge clk_i);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) push_exp(0, q0[0]);
      if (a1) push_exp(1, q1[0]);
      @(posedge clk_i);
      #1;
      if (a0) q0.delete(0);
      if (a1) q1.delete(0);
      req0_valid = (q0.size() != 0);
      if (q0.size() != 0) begin
        req0_src1 = q0[0].src1; req0_src2 = q0[0].src2;
        req0_ctrl = q0[0].ctrl; req0_comp = q0[0].comp;
      end
      req1_valid = (q1.size() != 0);
      if (q1.size() != 0) begin
        req1_src1 = q1[0].src1; req1_src2 = q1[0].src2;
        req1_ctrl = q1[0].ctrl; req1_comp = q1[0].comp;
      end
    end
  end

  task automatic mon_port(input int p, input logic vld, input logic rdy, input logic [31:0] res,
                          input logic z, input logic c, input logic v);
    if (!vld) return;
    if (!seen[p]) begin
      seen[p] = 1'b1;
      hold_res[p] = res;
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp%0d_unexpected: got valid response, expected none (cycle %0d)", p, cyc);
      end else begin
        check("rsp_port", p, sb[0].port);
        check("rsp_latency", cyc, sb[0].acc + 2);
      end
    end else begin
      check("rsp_stable", res, hold_res[p]);
    end
    if (rdy) begin
      seen[p] = 1'b0;
      if (p == 0) hs_cyc0 = cyc;
      if (sb.size() != 0) begin
        check("rsp_result", res, sb[0].res);
        check("rsp_zero", {31'd0, z}, {31'd0, sb[0].z});
        check("rsp_cout", {31'd0, c}, {31'd0, sb[0].c});
        check("rsp_ovf",  {31'd0, v}, {31'd0, sb[0].v});
        sb.delete(0);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    seen[0] = 1'b0; seen[1] = 1'b0;
    forever begin
      @(negedge clk_i);
      mon_port(0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_zero, rsp0_cout, rsp0_ovf);
      mon_port(1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_cout, rsp1_ovf);
    end
  end

  task automatic wait_done(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_i);
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !busy_o) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got pending work after 300 cycles, expected idle", name);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset_grant", {30'd0, grant_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("reset_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("reset_result", rsp0_result, 32'd0);
    @(posedge clk_i); #1;
    rst_n = 1'b1;

    // ADD 5+7 on port 0
    q0.push_back(mk(32'd5, 32'd7, ALU_ADD, 3'd0, 32'd12, 1'b0, 1'b0, 1'b0));
    wait_done("add");

    // Both requesting after reset: 0 first, then alternate
    do_reset();
    order.delete();
    q0.push_back(mk(32'h000000F0, 32'h0000000F, ALU_OR,  3'd0, 32'h000000FF, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(32'hFF00FF00, 32'h0FF00FF0, ALU_AND, 3'd0, 32'h0F000F00, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(32'h00000000, 32'h00000000, ALU_NOR, 3'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
    q1.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, ALU_NAND, 3'd0, 32'h00000000, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(32'hFFFFFFFF, 32'h00000001, ALU_ADD,  3'd0, 32'h00000000, 1'b1, 1'b1, 1'b0));
    q1.push_back(mk(32'd10,       32'd3,        ALU_SUB,  3'd0, 32'd7,        1'b0, 1'b1, 1'b0));
    wait_done("alternate");
    for (int i = 0; i < 6; i++)
      check("alt_order", (i < order.size()) ? order[i] : -1, i % 2);

    // rsp0 back-pressure while req1 waits
    @(posedge clk_i); #1;
    rsp0_ready = 1'b0;
    q0.push_back(mk(32'd3, 32'd3, ALU_SUB, 3'd0, 32'd0, 1'b1, 1'b1, 1'b0));
    q1.push_back(mk(32'h80000000, 32'd1, ALU_SUB, 3'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (rsp0_valid) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL hold_rsp0_timeout: got no rsp0_valid, expected one within 20 cycles");
    end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk_i);
      check("hold_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("hold_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      @(posedge clk_i); #1;
    end
    rsp0_ready = 1'b1;
    wait_done("hold");
    check("req1_after_hs", acc_cyc1, hs_cyc0 + 1);

    // Compare sub-codes with -1 vs 1
    q0.push_back(mk(32'hFFFFFFFF, 32'd1, ALU_COMP, CMP_SLT,  32'd1, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(32'hFFFFFFFF, 32'd1, ALU_COMP, CMP_SLTU, 32'd0, 1'b1, 1'b0, 1'b0));
    q0.push_back(mk(32'hFFFFFFFF, 32'd1, ALU_COMP, CMP_SGT,  32'd0, 1'b1, 1'b0, 1'b0));
    q0.push_back(mk(32'hFFFFFFFF, 32'd1, ALU_COMP, CMP_SLE,  32'd1, 1'b0, 1'b0, 1'b0));
    wait_done("comp");

    // Reset while the operation is in EXEC
    @(posedge clk_i); #1;
    q0.push_back(mk(32'd1, 32'd1, ALU_ADD, 3'd0, 32'd2, 1'b0, 1'b0, 1'b0));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (busy_o) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL exec_reset_timeout: got busy_o low, expected high within 20 cycles");
    end
    rst_n = 1'b0;
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("abort_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      check("abort_grant", {30'd0, grant_o}, 32'd0);
      check("abort_busy", {31'd0, busy_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    q1.push_back(mk(32'h7FFFFFFF, 32'd1, ALU_ADD, 3'd0, 32'h80000000, 1'b0, 1'b0, 1'b1));
    wait_done("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
